// File: rtl/axi4_pkg.sv
// =============================================================================
// Module      : axi4_pkg
// Description : Shared AXI4 field widths, encodings and slice FSM types.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package axi4_pkg;

    localparam int LEN_W    = 8;
    localparam int SIZE_W   = 3;
    localparam int BURST_W  = 2;
    localparam int CACHE_W  = 4;
    localparam int PROT_W   = 3;
    localparam int REGION_W = 4;
    localparam int RESP_W   = 2;

    typedef enum logic [BURST_W-1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    typedef enum logic [RESP_W-1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    typedef enum logic [SIZE_W-1:0] {
        SIZE_1B   = 3'd0,
        SIZE_2B   = 3'd1,
        SIZE_4B   = 3'd2,
        SIZE_8B   = 3'd3,
        SIZE_16B  = 3'd4,
        SIZE_32B  = 3'd5,
        SIZE_64B  = 3'd6,
        SIZE_128B = 3'd7
    } size_e;

    typedef enum logic [0:0] {
        BYPASS = 1'b0,
        SLICE  = 1'b1
    } slice_mode_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } slice_state_e;

endpackage

`default_nettype wire

// File: rtl/axi_skid_slice.sv
// =============================================================================
// Module      : axi_skid_slice
// Description : One valid/ready channel stage: combinational bypass or a
//               two-entry registered skid slice (main + skid register).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module axi_skid_slice
    import axi4_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] src_data_i,
    input  logic             src_valid_i,
    output logic             src_ready_o,
    output logic [WIDTH-1:0] dst_data_o,
    output logic             dst_valid_o,
    input  logic             dst_ready_i
);

    generate
        if (MODE == int'(BYPASS)) begin : g_bypass
            logic w_unused_bypass;

            assign dst_data_o      = src_data_i;
            assign dst_valid_o     = src_valid_i;
            assign src_ready_o     = dst_ready_i;
            assign w_unused_bypass = ^{clk_i, rst_i};
        end else begin : g_slice
            slice_state_e     state_q;
            logic [WIDTH-1:0] main_q;
            logic [WIDTH-1:0] skid_q;
            logic             valid_q;
            logic             ready_q;
            logic             w_in;
            logic             w_out;

            // ready_q is preset during reset so READY rises on the first free cycle
            assign src_ready_o = ready_q & ~rst_i;
            assign dst_valid_o = valid_q;
            assign dst_data_o  = main_q;
            assign w_in        = src_valid_i & src_ready_o;
            assign w_out       = valid_q & dst_ready_i;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end else begin
                    unique case (state_q)
                        EMPTY: begin
                            if (w_in) begin
                                main_q  <= src_data_i;
                                state_q <= ONE;
                                valid_q <= 1'b1;
                            end
                        end
                        ONE: begin
                            if (w_in && w_out) begin
                                main_q <= src_data_i;
                            end else if (w_in) begin
                                skid_q  <= src_data_i;
                                state_q <= FULL;
                                ready_q <= 1'b0;
                            end else if (w_out) begin
                                state_q <= EMPTY;
                                valid_q <= 1'b0;
                            end
                        end
                        FULL: begin
                            if (w_out) begin
                                main_q  <= skid_q;
                                state_q <= ONE;
                                ready_q <= 1'b1;
                            end
                        end
                        default: begin
                            state_q <= EMPTY;
                            valid_q <= 1'b0;
                            ready_q <= 1'b1;
                        end
                    endcase
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/axi4_reg_slice.sv
// =============================================================================
// Module      : axi4_reg_slice
// Description : AXI4 1:1 pipeline stage, per-channel bypass or skid slice.
//               Optional AxREGION decode: AXI4_REG_SLICE_REGION_DECODE_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module axi4_reg_slice
    import axi4_pkg::*;
#(
    parameter int ID_WIDTH   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int AW_MODE    = 1,
    parameter int W_MODE     = 1,
    parameter int B_MODE     = 1,
    parameter int AR_MODE    = 1,
    parameter int R_MODE     = 1,
    parameter int REGION_LSB = 28
) (
    input  logic                    clock,
    input  logic                    reset,
    // upstream (slave) side
    input  logic [ID_WIDTH-1:0]     s_axi_AWID,
    input  logic [ADDR_WIDTH-1:0]   s_axi_AWADDR,
    input  logic [LEN_W-1:0]        s_axi_AWLEN,
    input  logic [SIZE_W-1:0]       s_axi_AWSIZE,
    input  logic [BURST_W-1:0]      s_axi_AWBURST,
    input  logic                    s_axi_AWLOCK,
    input  logic [CACHE_W-1:0]      s_axi_AWCACHE,
    input  logic [PROT_W-1:0]       s_axi_AWPROT,
    input  logic                    s_axi_AWVALID,
    output logic                    s_axi_AWREADY,
    input  logic [DATA_WIDTH-1:0]   s_axi_WDATA,
    input  logic [DATA_WIDTH/8-1:0] s_axi_WSTRB,
    input  logic                    s_axi_WLAST,
    input  logic                    s_axi_WVALID,
    output logic                    s_axi_WREADY,
    output logic [ID_WIDTH-1:0]     s_axi_BID,
    output logic [RESP_W-1:0]       s_axi_BRESP,
    output logic                    s_axi_BVALID,
    input  logic                    s_axi_BREADY,
    input  logic [ID_WIDTH-1:0]     s_axi_ARID,
    input  logic [ADDR_WIDTH-1:0]   s_axi_ARADDR,
    input  logic [LEN_W-1:0]        s_axi_ARLEN,
    input  logic [SIZE_W-1:0]       s_axi_ARSIZE,
    input  logic [BURST_W-1:0]      s_axi_ARBURST,
    input  logic                    s_axi_ARLOCK,
    input  logic [CACHE_W-1:0]      s_axi_ARCACHE,
    input  logic [PROT_W-1:0]       s_axi_ARPROT,
    input  logic                    s_axi_ARVALID,
    output logic                    s_axi_ARREADY,
    output logic [ID_WIDTH-1:0]     s_axi_RID,
    output logic [DATA_WIDTH-1:0]   s_axi_RDATA,
    output logic [RESP_W-1:0]       s_axi_RRESP,
    output logic                    s_axi_RLAST,
    output logic                    s_axi_RVALID,
    input  logic                    s_axi_RREADY,
    // downstream (master) side
    output logic [ID_WIDTH-1:0]     m_axi_AWID,
    output logic [ADDR_WIDTH-1:0]   m_axi_AWADDR,
    output logic [LEN_W-1:0]        m_axi_AWLEN,
    output logic [SIZE_W-1:0]       m_axi_AWSIZE,
    output logic [BURST_W-1:0]      m_axi_AWBURST,
    output logic                    m_axi_AWLOCK,
    output logic [CACHE_W-1:0]      m_axi_AWCACHE,
    output logic [PROT_W-1:0]       m_axi_AWPROT,
    output logic [REGION_W-1:0]     m_axi_AWREGION,
    output logic                    m_axi_AWVALID,
    input  logic                    m_axi_AWREADY,
    output logic [DATA_WIDTH-1:0]   m_axi_WDATA,
    output logic [DATA_WIDTH/8-1:0] m_axi_WSTRB,
    output logic                    m_axi_WLAST,
    output logic                    m_axi_WVALID,
    input  logic                    m_axi_WREADY,
    input  logic [ID_WIDTH-1:0]     m_axi_BID,
    input  logic [RESP_W-1:0]       m_axi_BRESP,
    input  logic                    m_axi_BVALID,
    output logic                    m_axi_BREADY,
    output logic [ID_WIDTH-1:0]     m_axi_ARID,
    output logic [ADDR_WIDTH-1:0]   m_axi_ARADDR,
    output logic [LEN_W-1:0]        m_axi_ARLEN,
    output logic [SIZE_W-1:0]       m_axi_ARSIZE,
    output logic [BURST_W-1:0]      m_axi_ARBURST,
    output logic                    m_axi_ARLOCK,
    output logic [CACHE_W-1:0]      m_axi_ARCACHE,
    output logic [PROT_W-1:0]       m_axi_ARPROT,
    output logic [REGION_W-1:0]     m_axi_ARREGION,
    output logic                    m_axi_ARVALID,
    input  logic                    m_axi_ARREADY,
    input  logic [ID_WIDTH-1:0]     m_axi_RID,
    input  logic [DATA_WIDTH-1:0]   m_axi_RDATA,
    input  logic [RESP_W-1:0]       m_axi_RRESP,
    input  logic                    m_axi_RLAST,
    input  logic                    m_axi_RVALID,
    output logic                    m_axi_RREADY
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int AX_W   = ID_WIDTH + ADDR_WIDTH + LEN_W + SIZE_W + BURST_W + 1 + CACHE_W + PROT_W;
    localparam int W_W    = DATA_WIDTH + STRB_W + 1;
    localparam int B_W    = ID_WIDTH + RESP_W;
    localparam int R_W    = ID_WIDTH + DATA_WIDTH + RESP_W + 1;
`ifdef AXI4_REG_SLICE_REGION_DECODE_EN
    localparam int AX_PW  = AX_W + REGION_W;
`else
    localparam int AX_PW  = AX_W;
    localparam int REGION_LSB_UNUSED = REGION_LSB;
`endif

    logic [AX_W-1:0]  w_aw_base;
    logic [AX_W-1:0]  w_ar_base;
    logic [AX_PW-1:0] w_aw_src;
    logic [AX_PW-1:0] w_aw_dst;
    logic [AX_PW-1:0] w_ar_src;
    logic [AX_PW-1:0] w_ar_dst;
    logic [W_W-1:0]   w_w_src;
    logic [W_W-1:0]   w_w_dst;
    logic [B_W-1:0]   w_b_src;
    logic [B_W-1:0]   w_b_dst;
    logic [R_W-1:0]   w_r_src;
    logic [R_W-1:0]   w_r_dst;

    assign w_aw_base = {s_axi_AWID, s_axi_AWADDR, s_axi_AWLEN, s_axi_AWSIZE,
                        s_axi_AWBURST, s_axi_AWLOCK, s_axi_AWCACHE, s_axi_AWPROT};
    assign w_ar_base = {s_axi_ARID, s_axi_ARADDR, s_axi_ARLEN, s_axi_ARSIZE,
                        s_axi_ARBURST, s_axi_ARLOCK, s_axi_ARCACHE, s_axi_ARPROT};

    assign {m_axi_AWID, m_axi_AWADDR, m_axi_AWLEN, m_axi_AWSIZE,
            m_axi_AWBURST, m_axi_AWLOCK, m_axi_AWCACHE, m_axi_AWPROT} = w_aw_dst[AX_W-1:0];
    assign {m_axi_ARID, m_axi_ARADDR, m_axi_ARLEN, m_axi_ARSIZE,
            m_axi_ARBURST, m_axi_ARLOCK, m_axi_ARCACHE, m_axi_ARPROT} = w_ar_dst[AX_W-1:0];

`ifdef AXI4_REG_SLICE_REGION_DECODE_EN
    // Region rides in the top bits of the packed beat so it stays aligned with its address
    assign w_aw_src       = {s_axi_AWADDR[REGION_LSB +: REGION_W], w_aw_base};
    assign w_ar_src       = {s_axi_ARADDR[REGION_LSB +: REGION_W], w_ar_base};
    assign m_axi_AWREGION = w_aw_dst[AX_PW-1 -: REGION_W];
    assign m_axi_ARREGION = w_ar_dst[AX_PW-1 -: REGION_W];
`else
    assign w_aw_src       = w_aw_base;
    assign w_ar_src       = w_ar_base;
    assign m_axi_AWREGION = '0;
    assign m_axi_ARREGION = '0;
`endif

    assign w_w_src = {s_axi_WDATA, s_axi_WSTRB, s_axi_WLAST};
    assign {m_axi_WDATA, m_axi_WSTRB, m_axi_WLAST} = w_w_dst;

    assign w_b_src = {m_axi_BID, m_axi_BRESP};
    assign {s_axi_BID, s_axi_BRESP} = w_b_dst;

    assign w_r_src = {m_axi_RID, m_axi_RDATA, m_axi_RRESP, m_axi_RLAST};
    assign {s_axi_RID, s_axi_RDATA, s_axi_RRESP, s_axi_RLAST} = w_r_dst;

    axi_skid_slice #(.WIDTH(AX_PW), .MODE(AW_MODE)) u_aw_slice (
        .clk_i       (clock),
        .rst_i       (reset),
        .src_data_i  (w_aw_src),
        .src_valid_i (s_axi_AWVALID),
        .src_ready_o (s_axi_AWREADY),
        .dst_data_o  (w_aw_dst),
        .dst_valid_o (m_axi_AWVALID),
        .dst_ready_i (m_axi_AWREADY)
    );

    axi_skid_slice #(.WIDTH(W_W), .MODE(W_MODE)) u_w_slice (
        .clk_i       (clock),
        .rst_i       (reset),
        .src_data_i  (w_w_src),
        .src_valid_i (s_axi_WVALID),
        .src_ready_o (s_axi_WREADY),
        .dst_data_o  (w_w_dst),
        .dst_valid_o (m_axi_WVALID),
        .dst_ready_i (m_axi_WREADY)
    );

    axi_skid_slice #(.WIDTH(B_W), .MODE(B_MODE)) u_b_slice (
        .clk_i       (clock),
        .rst_i       (reset),
        .src_data_i  (w_b_src),
        .src_valid_i (m_axi_BVALID),
        .src_ready_o (m_axi_BREADY),
        .dst_data_o  (w_b_dst),
        .dst_valid_o (s_axi_BVALID),
        .dst_ready_i (s_axi_BREADY)
    );

    axi_skid_slice #(.WIDTH(AX_PW), .MODE(AR_MODE)) u_ar_slice (
        .clk_i       (clock),
        .rst_i       (reset),
        .src_data_i  (w_ar_src),
        .src_valid_i (s_axi_ARVALID),
        .src_ready_o (s_axi_ARREADY),
        .dst_data_o  (w_ar_dst),
        .dst_valid_o (m_axi_ARVALID),
        .dst_ready_i (m_axi_ARREADY)
    );

    axi_skid_slice #(.WIDTH(R_W), .MODE(R_MODE)) u_r_slice (
        .clk_i       (clock),
        .rst_i       (reset),
        .src_data_i  (w_r_src),
        .src_valid_i (m_axi_RVALID),
        .src_ready_o (m_axi_RREADY),
        .dst_data_o  (w_r_dst),
        .dst_valid_o (s_axi_RVALID),
        .dst_ready_i (s_axi_RREADY)
    );

endmodule

`default_nettype wire

// File: tb/tb_axi4_reg_slice.sv
// =============================================================================
// Module      : tb_axi4_reg_slice
// Description : Self-checking bench for axi4_reg_slice (B channel in bypass).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_axi4_reg_slice;

    logic         clock;
    logic         reset;
    logic [1:0]   s_axi_AWID, s_axi_ARID, m_axi_AWID, m_axi_ARID;
    logic [31:0]  s_axi_AWADDR, s_axi_ARADDR, m_axi_AWADDR, m_axi_ARADDR;
    logic [7:0]   s_axi_AWLEN, s_axi_ARLEN, m_axi_AWLEN, m_axi_ARLEN;
    logic [2:0]   s_axi_AWSIZE, s_axi_ARSIZE, m_axi_AWSIZE, m_axi_ARSIZE;
    logic [1:0]   s_axi_AWBURST, s_axi_ARBURST, m_axi_AWBURST, m_axi_ARBURST;
    logic         s_axi_AWLOCK, s_axi_ARLOCK, m_axi_AWLOCK, m_axi_ARLOCK;
    logic [3:0]   s_axi_AWCACHE, s_axi_ARCACHE, m_axi_AWCACHE, m_axi_ARCACHE;
    logic [2:0]   s_axi_AWPROT, s_axi_ARPROT, m_axi_AWPROT, m_axi_ARPROT;
    logic [3:0]   m_axi_AWREGION, m_axi_ARREGION;
    logic         s_axi_AWVALID, s_axi_AWREADY, m_axi_AWVALID, m_axi_AWREADY;
    logic         s_axi_ARVALID, s_axi_ARREADY, m_axi_ARVALID, m_axi_ARREADY;
    logic [127:0] s_axi_WDATA, m_axi_WDATA;
    logic [15:0]  s_axi_WSTRB, m_axi_WSTRB;
    logic         s_axi_WLAST, m_axi_WLAST;
    logic         s_axi_WVALID, s_axi_WREADY, m_axi_WVALID, m_axi_WREADY;
    logic [1:0]   s_axi_BID, m_axi_BID, s_axi_BRESP, m_axi_BRESP;
    logic         s_axi_BVALID, s_axi_BREADY, m_axi_BVALID, m_axi_BREADY;
    logic [1:0]   s_axi_RID, m_axi_RID, s_axi_RRESP, m_axi_RRESP;
    logic [127:0] s_axi_RDATA, m_axi_RDATA;
    logic         s_axi_RLAST, m_axi_RLAST;
    logic         s_axi_RVALID, s_axi_RREADY, m_axi_RVALID, m_axi_RREADY;

    axi4_reg_slice #(.B_MODE(0)) dut (
        .clock(clock), .reset(reset),
        .s_axi_AWID(s_axi_AWID), .s_axi_AWADDR(s_axi_AWADDR), .s_axi_AWLEN(s_axi_AWLEN),
        .s_axi_AWSIZE(s_axi_AWSIZE), .s_axi_AWBURST(s_axi_AWBURST), .s_axi_AWLOCK(s_axi_AWLOCK),
        .s_axi_AWCACHE(s_axi_AWCACHE), .s_axi_AWPROT(s_axi_AWPROT),
        .s_axi_AWVALID(s_axi_AWVALID), .s_axi_AWREADY(s_axi_AWREADY),
        .s_axi_WDATA(s_axi_WDATA), .s_axi_WSTRB(s_axi_WSTRB), .s_axi_WLAST(s_axi_WLAST),
        .s_axi_WVALID(s_axi_WVALID), .s_axi_WREADY(s_axi_WREADY),
        .s_axi_BID(s_axi_BID), .s_axi_BRESP(s_axi_BRESP),
        .s_axi_BVALID(s_axi_BVALID), .s_axi_BREADY(s_axi_BREADY),
        .s_axi_ARID(s_axi_ARID), .s_axi_ARADDR(s_axi_ARADDR), .s_axi_ARLEN(s_axi_ARLEN),
        .s_axi_ARSIZE(s_axi_ARSIZE), .s_axi_ARBURST(s_axi_ARBURST), .s_axi_ARLOCK(s_axi_ARLOCK),
        .s_axi_ARCACHE(s_axi_ARCACHE), .s_axi_ARPROT(s_axi_ARPROT),
        .s_axi_ARVALID(s_axi_ARVALID), .s_axi_ARREADY(s_axi_ARREADY),
        .s_axi_RID(s_axi_RID), .s_axi_RDATA(s_axi_RDATA), .s_axi_RRESP(s_axi_RRESP),
        .s_axi_RLAST(s_axi_RLAST), .s_axi_RVALID(s_axi_RVALID), .s_axi_RREADY(s_axi_RREADY),
        .m_axi_AWID(m_axi_AWID), .m_axi_AWADDR(m_axi_AWADDR), .m_axi_AWLEN(m_axi_AWLEN),
        .m_axi_AWSIZE(m_axi_AWSIZE), .m_axi_AWBURST(m_axi_AWBURST), .m_axi_AWLOCK(m_axi_AWLOCK),
        .m_axi_AWCACHE(m_axi_AWCACHE), .m_axi_AWPROT(m_axi_AWPROT), .m_axi_AWREGION(m_axi_AWREGION),
        .m_axi_AWVALID(m_axi_AWVALID), .m_axi_AWREADY(m_axi_AWREADY),
        .m_axi_WDATA(m_axi_WDATA), .m_axi_WSTRB(m_axi_WSTRB), .m_axi_WLAST(m_axi_WLAST),
        .m_axi_WVALID(m_axi_WVALID), .m_axi_WREADY(m_axi_WREADY),
        .m_axi_BID(m_axi_BID), .m_axi_BRESP(m_axi_BRESP),
        .m_axi_BVALID(m_axi_BVALID), .m_axi_BREADY(m_axi_BREADY),
        .m_axi_ARID(m_axi_ARID), .m_axi_ARADDR(m_axi_ARADDR), .m_axi_ARLEN(m_axi_ARLEN),
        .m_axi_ARSIZE(m_axi_ARSIZE), .m_axi_ARBURST(m_axi_ARBURST), .m_axi_ARLOCK(m_axi_ARLOCK),
        .m_axi_ARCACHE(m_axi_ARCACHE), .m_axi_ARPROT(m_axi_ARPROT), .m_axi_ARREGION(m_axi_ARREGION),
        .m_axi_ARVALID(m_axi_ARVALID), .m_axi_ARREADY(m_axi_ARREADY),
        .m_axi_RID(m_axi_RID), .m_axi_RDATA(m_axi_RDATA), .m_axi_RRESP(m_axi_RRESP),
        .m_axi_RLAST(m_axi_RLAST), .m_axi_RVALID(m_axi_RVALID), .m_axi_RREADY(m_axi_RREADY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

`ifdef AXI4_REG_SLICE_REGION_DECODE_EN
    function automatic logic [3:0] exp_region(input logic [3:0] r);
        return r;
    endfunction
`else
    function automatic logic [3:0] exp_region(input logic [3:0] r);
        return 4'h0 & r;
    endfunction
`endif

    // ---------------- scoreboard: source beats in, destination beats out ----------------
    logic [191:0] aw_s, aw_m, ar_s, ar_m, w_s, w_m, r_s, r_m;
    assign aw_s = 192'({s_axi_AWID, s_axi_AWADDR, s_axi_AWLEN, s_axi_AWSIZE, s_axi_AWBURST, s_axi_AWLOCK, s_axi_AWCACHE, s_axi_AWPROT});
    assign aw_m = 192'({m_axi_AWID, m_axi_AWADDR, m_axi_AWLEN, m_axi_AWSIZE, m_axi_AWBURST, m_axi_AWLOCK, m_axi_AWCACHE, m_axi_AWPROT});
    assign ar_s = 192'({s_axi_ARID, s_axi_ARADDR, s_axi_ARLEN, s_axi_ARSIZE, s_axi_ARBURST, s_axi_ARLOCK, s_axi_ARCACHE, s_axi_ARPROT});
    assign ar_m = 192'({m_axi_ARID, m_axi_ARADDR, m_axi_ARLEN, m_axi_ARSIZE, m_axi_ARBURST, m_axi_ARLOCK, m_axi_ARCACHE, m_axi_ARPROT});
    assign w_s  = 192'({s_axi_WDATA, s_axi_WSTRB, s_axi_WLAST});
    assign w_m  = 192'({m_axi_WDATA, m_axi_WSTRB, m_axi_WLAST});
    assign r_s  = 192'({m_axi_RID, m_axi_RDATA, m_axi_RRESP, m_axi_RLAST});
    assign r_m  = 192'({s_axi_RID, s_axi_RDATA, s_axi_RRESP, s_axi_RLAST});

    logic [191:0] aw_q[$], ar_q[$], w_q[$], r_q[$];
    logic [191:0] aw_prev, ar_prev, w_prev, r_prev;
    bit           aw_hold, ar_hold, w_hold, r_hold;
    int           w_out_cnt = 0, r_out_cnt = 0, r_last_cnt = 0, r_last_idx = -1;

    task automatic extra_beat(input string name, input logic [191:0] beat);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got unexpected beat %0h, required none", name, beat);
    endtask

    always @(negedge clock) begin
        if (reset) begin
            aw_q.delete(); ar_q.delete(); w_q.delete(); r_q.delete();
            aw_hold <= 1'b0; ar_hold <= 1'b0; w_hold <= 1'b0; r_hold <= 1'b0;
        end else begin
            if (s_axi_AWVALID && s_axi_AWREADY) aw_q.push_back(aw_s);
            if (s_axi_ARVALID && s_axi_ARREADY) ar_q.push_back(ar_s);
            if (s_axi_WVALID && s_axi_WREADY)   w_q.push_back(w_s);
            if (m_axi_RVALID && m_axi_RREADY)   r_q.push_back(r_s);

            if (m_axi_AWVALID && m_axi_AWREADY) begin
                if (aw_q.size() == 0) extra_beat("aw_extra", aw_m);
                else check("aw_order", 256'(aw_m), 256'(aw_q.pop_front()));
            end
            if (m_axi_ARVALID && m_axi_ARREADY) begin
                if (ar_q.size() == 0) extra_beat("ar_extra", ar_m);
                else check("ar_order", 256'(ar_m), 256'(ar_q.pop_front()));
            end
            if (m_axi_WVALID && m_axi_WREADY) begin
                w_out_cnt <= w_out_cnt + 1;
                if (w_q.size() == 0) extra_beat("w_extra", w_m);
                else check("w_order", 256'(w_m), 256'(w_q.pop_front()));
            end
            if (s_axi_RVALID && s_axi_RREADY) begin
                r_out_cnt <= r_out_cnt + 1;
                if (s_axi_RLAST) begin
                    r_last_cnt <= r_last_cnt + 1;
                    r_last_idx <= r_out_cnt;
                end
                if (r_q.size() == 0) extra_beat("r_extra", r_m);
                else check("r_order", 256'(r_m), 256'(r_q.pop_front()));
            end

            // a stalled destination beat must stay valid and unchanged
            if (aw_hold) check("aw_stable", 256'({m_axi_AWVALID, aw_m}), 256'({1'b1, aw_prev}));
            if (ar_hold) check("ar_stable", 256'({m_axi_ARVALID, ar_m}), 256'({1'b1, ar_prev}));
            if (w_hold)  check("w_stable",  256'({m_axi_WVALID, w_m}),   256'({1'b1, w_prev}));
            if (r_hold)  check("r_stable",  256'({s_axi_RVALID, r_m}),   256'({1'b1, r_prev}));
            aw_hold <= m_axi_AWVALID && !m_axi_AWREADY; aw_prev <= aw_m;
            ar_hold <= m_axi_ARVALID && !m_axi_ARREADY; ar_prev <= ar_m;
            w_hold  <= m_axi_WVALID && !m_axi_WREADY;   w_prev  <= w_m;
            r_hold  <= s_axi_RVALID && !s_axi_RREADY;   r_prev  <= r_m;
        end
    end

    // ---------------- address vectors ----------------
    typedef struct {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  region;
    } ax_vec_t;

    localparam int NV = 5;
    ax_vec_t vec[NV];
    bit      w_ready_exp[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    task automatic drive_ax(input int i);
        s_axi_AWID = vec[i].id;          s_axi_ARID = ~vec[i].id;
        s_axi_AWADDR = vec[i].addr;      s_axi_ARADDR = vec[i].addr;
        s_axi_AWLEN = vec[i].len;        s_axi_ARLEN = vec[i].len;
        s_axi_AWSIZE = 3'(i);            s_axi_ARSIZE = 3'(i + 2);
        s_axi_AWBURST = 2'(i % 3);       s_axi_ARBURST = 2'((i + 1) % 3);
        s_axi_AWLOCK = 1'(i);            s_axi_ARLOCK = ~1'(i);
        s_axi_AWCACHE = 4'(i * 3);       s_axi_ARCACHE = 4'(15 - i);
        s_axi_AWPROT = 3'(i);            s_axi_ARPROT = 3'(7 - i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{id: 2'd1, addr: 32'h1000_0040, len: 8'd3,   region: 4'h1};
        vec[1] = '{id: 2'd2, addr: 32'h3000_0000, len: 8'd0,   region: 4'h3};
        vec[2] = '{id: 2'd3, addr: 32'hF234_5678, len: 8'd255, region: 4'hF};
        vec[3] = '{id: 2'd0, addr: 32'h0000_0000, len: 8'd7,   region: 4'h0};
        vec[4] = '{id: 2'd2, addr: 32'h8FFF_FFFC, len: 8'd15,  region: 4'h8};

        reset = 1'b1;
        s_axi_AWVALID = 0; s_axi_ARVALID = 0; s_axi_WVALID = 0; s_axi_BREADY = 0; s_axi_RREADY = 0;
        m_axi_AWREADY = 0; m_axi_ARREADY = 0; m_axi_WREADY = 0; m_axi_BVALID = 0; m_axi_RVALID = 0;
        s_axi_WDATA = '0; s_axi_WSTRB = '0; s_axi_WLAST = 0;
        m_axi_BID = 0; m_axi_BRESP = 0; m_axi_RID = 0; m_axi_RDATA = '0; m_axi_RRESP = 0; m_axi_RLAST = 0;
        drive_ax(0);

        // reset state
        step();
        check("rst_s_awready", 256'(s_axi_AWREADY), 256'(0));
        check("rst_s_wready",  256'(s_axi_WREADY),  256'(0));
        check("rst_s_arready", 256'(s_axi_ARREADY), 256'(0));
        check("rst_m_rready",  256'(m_axi_RREADY),  256'(0));
        check("rst_valids", 256'({m_axi_AWVALID, m_axi_WVALID, m_axi_ARVALID, s_axi_RVALID}), 256'(0));
        step();
        reset = 1'b0;
        #1;
        check("post_rst_readys", 256'({s_axi_AWREADY, s_axi_WREADY, s_axi_ARREADY, m_axi_RREADY}), 256'(4'hF));

        // back-to-back AW/AR beats from the vector table
        m_axi_AWREADY = 1; m_axi_ARREADY = 1;
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) begin
                drive_ax(i);
                s_axi_AWVALID = 1; s_axi_ARVALID = 1;
            end else begin
                s_axi_AWVALID = 0; s_axi_ARVALID = 0;
            end
            #1;
            if (i == 0) check("aw_latency_pre", 256'(m_axi_AWVALID), 256'(0));
            if (i < NV) begin
                check("aw_sready", 256'(s_axi_AWREADY), 256'(1));
                check("ar_sready", 256'(s_axi_ARREADY), 256'(1));
            end
            step();
            if (i < NV) begin
                check("aw_mvalid", 256'(m_axi_AWVALID), 256'(1));
                check("aw_fields", 256'({m_axi_AWID, m_axi_AWADDR, m_axi_AWLEN}), 256'({vec[i].id, vec[i].addr, vec[i].len}));
                check("aw_region", 256'(m_axi_AWREGION), 256'(exp_region(vec[i].region)));
                check("ar_mvalid", 256'(m_axi_ARVALID), 256'(1));
                check("ar_fields", 256'({m_axi_ARID, m_axi_ARADDR}), 256'({~vec[i].id, vec[i].addr}));
                check("ar_region", 256'(m_axi_ARREGION), 256'(exp_region(vec[i].region)));
            end else begin
                check("ax_drain", 256'({m_axi_AWVALID, m_axi_ARVALID}), 256'(0));
            end
        end

        // W stream with a 2-cycle downstream stall
        begin
            int beat = 0;
            for (int c = 0; c < 8; c++) begin
                s_axi_WVALID = (beat < 4);
                s_axi_WDATA  = 128'(beat);
                s_axi_WSTRB  = 16'(1 << beat);
                s_axi_WLAST  = (beat == 3);
                m_axi_WREADY = !(c == 2 || c == 3);
                #1;
                if (c < 6) check("w_sready", 256'(s_axi_WREADY), 256'(w_ready_exp[c]));
                if (c == 3) check("w_held", 256'({m_axi_WVALID, m_axi_WDATA}), 256'({1'b1, 128'd1}));
                if (s_axi_WVALID && s_axi_WREADY) beat++;
                step();
            end
            s_axi_WVALID = 0;
            check("w_count", 256'(w_out_cnt), 256'(4));
        end

        // R stream with upstream RREADY toggling 1010
        begin
            int rb = 0;
            for (int c = 0; c < 40 && r_out_cnt < 6; c++) begin
                m_axi_RVALID = (rb < 6);
                m_axi_RID    = 2'(rb);
                m_axi_RDATA  = 128'(32'hA000 + rb);
                m_axi_RRESP  = 2'(rb % 4);
                m_axi_RLAST  = (rb == 5);
                s_axi_RREADY = (c % 2 == 0);
                #1;
                if (m_axi_RVALID && m_axi_RREADY) rb++;
                step();
            end
            m_axi_RVALID = 0; s_axi_RREADY = 1;
            check("r_count", 256'(r_out_cnt), 256'(6));
            check("r_last_count", 256'(r_last_cnt), 256'(1));
            check("r_last_final", 256'(r_last_idx), 256'(5));
        end

        // reset while AR holds two beats
        m_axi_ARREADY = 0;
        s_axi_ARADDR = 32'h0000_1111; s_axi_ARVALID = 1;
        #1; check("arf_accept0", 256'(s_axi_ARREADY), 256'(1));
        step();
        s_axi_ARADDR = 32'h0000_2222;
        #1; check("arf_accept1", 256'(s_axi_ARREADY), 256'(1));
        step();
        s_axi_ARVALID = 0;
        #1;
        check("arf_full", 256'({s_axi_ARREADY, m_axi_ARVALID, m_axi_ARADDR}), 256'({1'b0, 1'b1, 32'h0000_1111}));
        reset = 1;
        step();
        check("arf_rst_valid", 256'(m_axi_ARVALID), 256'(0));
        check("arf_rst_ready", 256'(s_axi_ARREADY), 256'(0));
        reset = 0; m_axi_ARREADY = 1;
        #1;
        check("arf_post_ready", 256'(s_axi_ARREADY), 256'(1));
        for (int c = 0; c < 4; c++) begin
            step();
            check("arf_no_ghost", 256'(m_axi_ARVALID), 256'(0));
        end

        // B bypass: combinational in both directions
        for (int k = 0; k < 4; k++) begin
            m_axi_BVALID = k[0];
            s_axi_BREADY = k[1];
            m_axi_BID    = 2'($urandom_range(0, 3));
            m_axi_BRESP  = 2'($urandom_range(0, 3));
            #1;
            check("b_valid", 256'(s_axi_BVALID), 256'(k[0]));
            check("b_ready", 256'(m_axi_BREADY), 256'(k[1]));
            check("b_payload", 256'({s_axi_BID, s_axi_BRESP}), 256'({m_axi_BID, m_axi_BRESP}));
            step();
        end
        m_axi_BVALID = 0;

        step();
        check("queues_empty", 256'(aw_q.size() + ar_q.size() + w_q.size() + r_q.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi4_reg_slice.md
Name: axi4_reg_slice

Overview:
- Parametrised AXI4 1:1 master-to-slave pipeline stage.
- Successor to the flat combinational slave-to-master passthrough: same signal set, but with configurable ID/ADDR/DATA widths.
- Each of the five channels can be set to bypass or to a two-entry registered skid slice.
- Inserted between a NIC slave port and a memory master port to break timing paths without losing throughput.

Parameters:
ID_WIDTH, 2, AxID/xID width
ADDR_WIDTH, 32, AxADDR width
DATA_WIDTH, 128, xDATA width; multiple of 8; STRB width = DATA_WIDTH/8
AW_MODE, 1, 0 = bypass (combinational), 1 = registered slice
W_MODE, 1, as AW_MODE, for W
B_MODE, 1, as AW_MODE, for B
AR_MODE, 1, as AW_MODE, for AR
R_MODE, 1, as AW_MODE, for R
REGION_LSB, 28, lowest address bit of AxREGION decode (feature only); REGION_LSB+3 < ADDR_WIDTH

Ports:
clock  in  1  single clock; all logic rising-edge
reset  in  1  synchronous, active-high
s_axi_AW{ID,ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT}  in  ID_WIDTH,ADDR_WIDTH,8,3,2,1,4,3  write address payload from upstream
s_axi_AWVALID in 1 / s_axi_AWREADY out 1  AW handshake
s_axi_W{DATA,STRB,LAST}  in  DATA_WIDTH,DATA_WIDTH/8,1  write data payload
s_axi_WVALID in 1 / s_axi_WREADY out 1  W handshake
s_axi_B{ID,RESP}  out  ID_WIDTH,2  write response payload
s_axi_BVALID out 1 / s_axi_BREADY in 1  B handshake
s_axi_AR{...}  in  same widths as AW  read address payload
s_axi_ARVALID in 1 / s_axi_ARREADY out 1  AR handshake
s_axi_R{ID,DATA,RESP,LAST}  out  ID_WIDTH,DATA_WIDTH,2,1  read data payload
s_axi_RVALID out 1 / s_axi_RREADY in 1  R handshake
m_axi_*  mirror of s_axi_* with opposite directions, plus:
m_axi_AWREGION out 4 / m_axi_ARREGION out 4  region outputs to downstream

Behaviour:
- Bypass mode: dst payload/VALID = src payload/VALID; src READY = dst READY; zero latency, no state.
- Slice mode uses a per-channel FSM with states EMPTY, ONE, FULL:
  - main register drives dst payload and VALID; skid register holds one extra beat.
  - src READY is registered: READY = (state != FULL) and not reset.
- Slice transitions (in = src VALID&READY, out = dst VALID&READY):
  - EMPTY + in -> ONE (beat loaded into main).
  - ONE + in + out -> ONE (main reloaded).
  - ONE + in + !out -> FULL (beat into skid).
  - ONE + !in + out -> EMPTY.
  - FULL + out -> ONE (skid moves to main).
  - FULL never accepts new input.
- Slice latency: 1 cycle from source handshake to dst VALID. Sustained throughput: 1 beat/cycle.
- Ordering: beats leave in acceptance order; payload is never modified except REGION.
- Once dst VALID is high, dst payload stays stable until the dst handshake completes (AXI rule).
- Reset (synchronous, any cycle, including mid-burst):
  - all FSMs -> EMPTY; all dst VALID = 0; all src READY = 0 during reset, 1 on the first cycle after reset deasserts.
  - in-flight beats are discarded.
  - payload registers are not reset; their contents are don't-care while VALID = 0.
- Bypass channels have no reset state.
- AWREGION/ARREGION = 0 when the feature is absent.
- Channels are fully independent; no AW/W coupling.

Optional Feature:
- Macro: AXI4_REG_SLICE_REGION_DECODE_EN.
- Defined: m_axi_AxREGION = AxADDR[REGION_LSB+3:REGION_LSB], taken from the same beat and registered alongside the payload in slice mode.
- Undefined: AxREGION tied to 4'h0; no extra flops.

Decomposition:
- Package axi4_pkg holds:
  - burst/resp/size typedefs;
  - localparams LEN_W = 8, SIZE_W = 3, BURST_W = 2, CACHE_W = 4, PROT_W = 3, REGION_W = 4;
  - slice_mode_e (BYPASS = 0, SLICE = 1);
  - slice_state_e (EMPTY, ONE, FULL).
- Sub-module axi_skid_slice (params WIDTH, MODE) holds the handshake/FSM. Instantiate it five times; each channel's payload fields are packed into one vector.

Test Plan:
- Reset, then AWVALID = 1, AWADDR = 32'h1000_0040, AWLEN = 3, m AWREADY = 1 -> m_axi_AWVALID high exactly 1 cycle after the handshake, payload identical, AWREADY stays 1.
- W stream of 4 beats DATA = 0,1,2,3 with m WREADY low for 2 cycles after beat 1:
  - s WREADY drops only once the slice is FULL;
  - m receives 0,1,2,3 in order; no loss or duplication.
- R channel, m RVALID every cycle, s RREADY toggling 1010 -> all beats delivered in order; RLAST = 1 only on the final beat.
- Assert reset while AR is FULL (2 beats held) -> next cycle m ARVALID = 0, s ARREADY = 0; cycle after reset deasserts, s ARREADY = 1; no held beat ever emitted.
- Feature defined, ARADDR = 32'h3000_0000 -> ARREGION = 4'h3. Feature undefined -> ARREGION = 4'h0.
- B_MODE = 0 -> s BVALID follows m BVALID the same cycle and m BREADY = s BREADY combinationally.
